adder_operand_queue: RTL and testbench

//  Upstream feeder and result stage for the 4-bit top_adder.
//  - Buffers operand pairs arriving on a valid/ready stream in a small FIFO.
//  - Presents the FIFO head on InA/InB and captures OutSum/overflow one cycle later.
//  - Delivers each result on a valid/ready output stream.
//  - Keeps a saturating count of overflowed additions.

---
 rtl/adder_pkg.sv | 9 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/adder_operand_queue.sv | 80 ++++++++
 tb/tb_adder_operand_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types for the 4-bit adder operand path: data width and the packed operand pair.
package adder_pkg;
    localparam int DATA_W = 4;

    typedef struct packed {
        logic [DATA_W-1:0] A;
        logic [DATA_W-1:0] B;
    } op_pair_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; head entry is visible on rdData (no bypass).
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic             doPush;
    logic             doPop;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;
    assign rdData = mem[rdPtr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/adder_operand_queue.sv
// Operand FIFO feeding the external top_adder, plus a registered result stream and
// a saturating count of overflowed additions.
module adder_operand_queue
    import adder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              OpValid,
    output logic              OpReady,
    input  logic [DATA_W-1:0] OpA,
    input  logic [DATA_W-1:0] OpB,
    output logic [DATA_W-1:0] InA,
    output logic [DATA_W-1:0] InB,
    input  logic [DATA_W-1:0] OutSum,
    input  logic              overflow,
    output logic              ResValid,
    input  logic              ResReady,
    output logic [DATA_W-1:0] ResSum,
    output logic              ResOvf,
    output logic [CNT_W-1:0]  OvfCount,
    input  logic              CntClr
);
    op_pair_t wrPair;
    op_pair_t headPair;
    logic     fifoFull;
    logic     fifoEmpty;
    logic     push;
    logic     pop;

    assign wrPair  = {OpA, OpB};
    assign OpReady = ~fifoFull;
    assign push    = OpValid & OpReady;
    assign pop     = ~fifoEmpty & (~ResValid | ResReady);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*DATA_W)
    ) opFifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .wrData (wrPair),
        .rdData (headPair),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    // Stale storage must never reach the adder while the queue is empty.
    assign InA = fifoEmpty ? '0 : headPair.A;
    assign InB = fifoEmpty ? '0 : headPair.B;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ResValid <= 1'b0;
            ResSum   <= '0;
            ResOvf   <= 1'b0;
        end else if (pop) begin
            ResValid <= 1'b1;
            ResSum   <= OutSum;
            ResOvf   <= overflow;
        end else if (ResValid && ResReady) begin
            ResValid <= 1'b0;
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OvfCount <= '0;
        end else if (CntClr) begin
            OvfCount <= '0;
        end else if (pop && overflow && (OvfCount != '1)) begin
            OvfCount <= OvfCount + 1'b1;
        end
    end
endmodule

// File: tb/tb_adder_operand_queue.sv
// Scoreboard bench for adder_operand_queue with a behavioural top_adder (unsigned carry-out).
module tb_adder_operand_queue;
    logic       clk;
    logic       rst_n;
    logic       OpValid, OpReady, ResValid, ResReady, ResOvf, CntClr, overflow;
    logic [3:0] OpA, OpB, InA, InB, OutSum, ResSum;
    logic [7:0] OvfCount;

    logic       OpValid2, OpReady2, ResValid2, ResOvf2, overflow2;
    logic [3:0] OpA2, OpB2, InA2, InB2, OutSum2, ResSum2;
    logic [1:0] OvfCount2;

    int checks = 0;
    int errors = 0;
    int hsCount = 0;
    logic [4:0] expQ[$];
    logic [4:0] expE;

    assign {overflow, OutSum}   = {1'b0, InA} + {1'b0, InB};
    assign {overflow2, OutSum2} = {1'b0, InA2} + {1'b0, InB2};

    adder_operand_queue #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .OpValid(OpValid), .OpReady(OpReady),
        .OpA(OpA), .OpB(OpB), .InA(InA), .InB(InB), .OutSum(OutSum),
        .overflow(overflow), .ResValid(ResValid), .ResReady(ResReady),
        .ResSum(ResSum), .ResOvf(ResOvf), .OvfCount(OvfCount), .CntClr(CntClr)
    );

    adder_operand_queue #(.DEPTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .OpValid(OpValid2), .OpReady(OpReady2),
        .OpA(OpA2), .OpB(OpB2), .InA(InA2), .InB(InB2), .OutSum(OutSum2),
        .overflow(overflow2), .ResValid(ResValid2), .ResReady(1'b1),
        .ResSum(ResSum2), .ResOvf(ResOvf2), .OvfCount(OvfCount2), .CntClr(1'b0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Result monitor: every accepted output is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ResValid && ResReady) begin
            hsCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resUnexpected: got sum %0h ovf %0b, expected no result", ResSum, ResOvf);
            end else begin
                expE = expQ.pop_front();
                chk("resSum", 32'(ResSum), 32'(expE[3:0]));
                chk("resOvf", 32'(ResOvf), 32'(expE[4]));
            end
        end
    end

    task automatic sendOpS(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] s, input logic o, output int stalls);
        int n;
        OpA = a;
        OpB = b;
        OpValid = 1'b1;
        stalls = 0;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (OpReady) break;
            stalls++;
            @(posedge clk);
            #1;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL opAccept: got OpReady=0 for 50 cycles, expected acceptance");
        end else begin
            expQ.push_back({o, s});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sendOp(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] s, input logic o);
        int st;
        sendOpS(a, b, s, o, st);
    endtask

    task automatic waitDrain();
        int n;
        for (n = 0; n < 100; n++) begin
            if (expQ.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int stalls;
        int st;
        int h0;
        logic [3:0] a, b, s;
        logic c;

        rst_n = 1'b0; OpValid = 1'b0; OpA = '0; OpB = '0; ResReady = 1'b0; CntClr = 1'b0;
        OpValid2 = 1'b0; OpA2 = '0; OpB2 = '0;
        #1;
        chk("rstResValid", 32'(ResValid), 32'd0);
        chk("rstOpReady", 32'(OpReady), 32'd1);
        chk("rstInA", 32'(InA), 32'd0);
        chk("rstOvfCount", 32'(OvfCount), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postRstOpReady", 32'(OpReady), 32'd1);

        // Single op latency
        ResReady = 1'b1;
        sendOp(4'b0001, 4'b0010, 4'b0011, 1'b0);
        OpValid = 1'b0;
        chk("latNotYet", 32'(ResValid), 32'd0);
        @(posedge clk); #1;
        chk("latValid", 32'(ResValid), 32'd1);
        chk("latSum", 32'(ResSum), 32'd3);
        waitDrain();

        // Fill under backpressure
        ResReady = 1'b0;
        sendOp(4'd1, 4'd1, 4'd2,  1'b0);
        sendOp(4'd2, 4'd3, 4'd5,  1'b0);
        sendOp(4'd4, 4'd4, 4'd8,  1'b0);
        sendOp(4'd7, 4'd8, 4'd15, 1'b0);
        sendOp(4'd6, 4'd3, 4'd9,  1'b0);
        OpValid = 1'b0;
        chk("fullOpReady", 32'(OpReady), 32'd0);
        chk("holdSum", 32'(ResSum), 32'd2);
        @(posedge clk); #1;
        chk("holdSum2", 32'(ResSum), 32'd2);
        chk("fullOpReady2", 32'(OpReady), 32'd0);
        ResReady = 1'b1;
        waitDrain();

        // Overflow counting and clear priority
        sendOp(4'b1010, 4'b1010, 4'b0100, 1'b1);
        sendOp(4'b1010, 4'b1010, 4'b0100, 1'b1);
        sendOp(4'b1010, 4'b1010, 4'b0100, 1'b1);
        OpValid = 1'b0;
        waitDrain();
        chk("ovfCount3", 32'(OvfCount), 32'd3);
        sendOp(4'b1010, 4'b1010, 4'b0100, 1'b1);
        OpValid = 1'b0;
        CntClr = 1'b1;
        @(posedge clk); #1;
        CntClr = 1'b0;
        chk("clrPopValid", 32'(ResValid), 32'd1);
        chk("clrOvfCount", 32'(OvfCount), 32'd0);
        waitDrain();

        // Saturation on the 2-bit counter instance
        OpA2 = 4'b1010; OpB2 = 4'b1010; OpValid2 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        OpValid2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("satCount", 32'(OvfCount2), 32'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("satHold", 32'(OvfCount2), 32'd3);

        // Streaming at full rate
        stalls = 0;
        h0 = hsCount;
        for (int i = 0; i < 20; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            {c, s} = {1'b0, a} + {1'b0, b};
            sendOpS(a, b, s, c, st);
            stalls += st;
        end
        OpValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("streamCount", 32'(hsCount - h0), 32'd20);
        chk("streamStalls", 32'(stalls), 32'd0);
        waitDrain();

        // Asynchronous reset with queued work
        CntClr = 1'b1;
        @(posedge clk); #1;
        CntClr = 1'b0;
        ResReady = 1'b0;
        sendOp(4'b1010, 4'b1010, 4'b0100, 1'b1);
        sendOp(4'd1, 4'd1, 4'd2, 1'b0);
        sendOp(4'd2, 4'd2, 4'd4, 1'b0);
        sendOp(4'd3, 4'd3, 4'd6, 1'b0);
        OpValid = 1'b0;
        @(posedge clk); #1;
        chk("preRstOvf", 32'(OvfCount), 32'd1);
        chk("preRstInA", 32'(InA), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        expQ.delete();
        chk("midRstResValid", 32'(ResValid), 32'd0);
        chk("midRstOpReady", 32'(OpReady), 32'd1);
        chk("midRstOvfCount", 32'(OvfCount), 32'd0);
        chk("midRstInA", 32'(InA), 32'd0);
        chk("midRstInB", 32'(InB), 32'd0);
        chk("midRstResSum", 32'(ResSum), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ResReady = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("afterRstResValid", 32'(ResValid), 32'd0);
        chk("afterRstInA", 32'(InA), 32'd0);
        chk("afterRstOpReady", 32'(OpReady), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
